// File: rtl/agu_arbiter.sv
// Round-robin arbiter granting a load or store requester exclusive use of one AGU.
// Latency: request in IDLE to O_AGU_Req 1 cycle; requests simply wait (level-held) while the AGU is owned.
module agu_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              I_Ld_Req,
    input  logic [ADDR_W-1:0] I_Ld_Length,
    input  logic [ADDR_W-1:0] I_Ld_Stride,
    input  logic [ADDR_W-1:0] I_Ld_Base,
    output logic              O_Ld_Gnt,
    output logic              O_Ld_Done,

    input  logic              I_St_Req,
    input  logic [ADDR_W-1:0] I_St_Length,
    input  logic [ADDR_W-1:0] I_St_Stride,
    input  logic [ADDR_W-1:0] I_St_Base,
    output logic              O_St_Gnt,
    output logic              O_St_Done,

    output logic              O_AGU_Req,
    output logic [ADDR_W-1:0] O_AGU_Length,
    output logic [ADDR_W-1:0] O_AGU_Stride,
    output logic [ADDR_W-1:0] O_AGU_Base,
    output logic              O_AGU_We,
    input  logic              I_AGU_End,

    output logic              O_Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              last_st_q;
    logic              any_req;
    logic              pick_st;
    logic              launch;
    logic [ADDR_W-1:0] sel_length;

    // Store wins only when it is alone or the load owned the previous access.
    always_comb begin
        any_req    = I_Ld_Req | I_St_Req;
        pick_st    = I_St_Req & (~I_Ld_Req | ~last_st_q);
        sel_length = pick_st ? I_St_Length : I_Ld_Length;
        launch     = (state_q == IDLE) & any_req;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = (sel_length == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: state_d = RUN;
            RUN: begin
                if (I_AGU_End) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The last-owner bit doubles as the current owner while the AGU is busy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_st_q    <= 1'b1;
            O_AGU_Length <= '0;
            O_AGU_Stride <= '0;
            O_AGU_Base   <= '0;
            O_AGU_We     <= 1'b0;
        end else if (launch) begin
            last_st_q    <= pick_st;
            O_AGU_Length <= sel_length;
            O_AGU_Stride <= pick_st ? I_St_Stride : I_Ld_Stride;
            O_AGU_Base   <= pick_st ? I_St_Base   : I_Ld_Base;
            O_AGU_We     <= pick_st;
        end
    end

    assign O_Busy    = (state_q != IDLE);
    assign O_Ld_Gnt  = O_Busy & ~last_st_q;
    assign O_St_Gnt  = O_Busy &  last_st_q;
    assign O_Ld_Done = (state_q == DONE) & ~last_st_q;
    assign O_St_Done = (state_q == DONE) &  last_st_q;
    assign O_AGU_Req = (state_q == ISSUE);

endmodule

// File: tb/tb_agu_arbiter.sv
// Self-checking bench for agu_arbiter: vector table, directed corner sequences, random vs transaction model.
module tb_agu_arbiter;

    localparam int W = 32;

    logic         clock;
    logic         reset;
    logic         ld_req, st_req, agu_end;
    logic [W-1:0] ld_len, ld_stride, ld_base;
    logic [W-1:0] st_len, st_stride, st_base;
    logic         ld_gnt, ld_done, st_gnt, st_done;
    logic         agu_req, agu_we, busy;
    logic [W-1:0] agu_len, agu_stride, agu_base;
    logic [6:0]   flags;

    int n_checks = 0;
    int n_pass   = 0;

    agu_arbiter #(.ADDR_W(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .I_Ld_Req    (ld_req),
        .I_Ld_Length (ld_len),
        .I_Ld_Stride (ld_stride),
        .I_Ld_Base   (ld_base),
        .O_Ld_Gnt    (ld_gnt),
        .O_Ld_Done   (ld_done),
        .I_St_Req    (st_req),
        .I_St_Length (st_len),
        .I_St_Stride (st_stride),
        .I_St_Base   (st_base),
        .O_St_Gnt    (st_gnt),
        .O_St_Done   (st_done),
        .O_AGU_Req   (agu_req),
        .O_AGU_Length(agu_len),
        .O_AGU_Stride(agu_stride),
        .O_AGU_Base  (agu_base),
        .O_AGU_We    (agu_we),
        .I_AGU_End   (agu_end),
        .O_Busy      (busy)
    );

    assign flags = {ld_gnt, st_gnt, ld_done, st_done, agu_req, agu_we, busy};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step;
        @(negedge clock);
    endtask

    task automatic do_reset;
        reset   = 1'b0;
        ld_req  = 1'b0;
        st_req  = 1'b0;
        agu_end = 1'b0;
        step();
        reset = 1'b1;
    endtask

    // Flags order: {ld_gnt, st_gnt, ld_done, st_done, agu_req, we, busy}
    typedef struct {
        logic         ld_req;
        logic         st_req;
        logic [W-1:0] ld_len;
        logic [W-1:0] st_len;
        logic         agu_end;
        logic [6:0]   exp_flags;
        logic [W-1:0] exp_len;
    } vec_t;

    vec_t tbl[12];

    // Transaction-level reference model
    bit           m_busy, m_st, m_fin, m_last_st, m_we;
    int           m_age;
    logic [W-1:0] m_len, m_stride, m_base;

    initial begin
        bit got_st [$];
        int viol;
        logic [6:0] e_flags;

        reset = 1'b0;
        ld_req = 0; st_req = 0; agu_end = 0;
        ld_len = 0; st_len = 0;
        ld_stride = 32'd2; ld_base = 32'h100;
        st_stride = 32'd4; st_base = 32'h200;
        #1;
        check("reset_flags",  {25'd0, flags}, 32'd0);
        check("reset_len",    agu_len, 32'd0);
        check("reset_base",   agu_base, 32'd0);
        step();
        reset = 1'b1;

        tbl[0]  = '{1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 7'b0000000, 32'd0};
        tbl[1]  = '{1'b1, 1'b1, 32'd3, 32'd5, 1'b0, 7'b1000101, 32'd3};
        tbl[2]  = '{1'b1, 1'b1, 32'd3, 32'd5, 1'b1, 7'b1000001, 32'd3};
        tbl[3]  = '{1'b1, 1'b1, 32'd3, 32'd5, 1'b0, 7'b1000001, 32'd3};
        tbl[4]  = '{1'b1, 1'b1, 32'd3, 32'd5, 1'b1, 7'b1010001, 32'd3};
        tbl[5]  = '{1'b1, 1'b1, 32'd3, 32'd5, 1'b0, 7'b0000000, 32'd3};
        tbl[6]  = '{1'b1, 1'b1, 32'd3, 32'd5, 1'b0, 7'b0100111, 32'd5};
        tbl[7]  = '{1'b1, 1'b0, 32'd3, 32'd5, 1'b0, 7'b0100011, 32'd5};
        tbl[8]  = '{1'b0, 1'b0, 32'd3, 32'd5, 1'b1, 7'b0101011, 32'd5};
        tbl[9]  = '{1'b0, 1'b1, 32'd3, 32'd0, 1'b0, 7'b0000010, 32'd5};
        tbl[10] = '{1'b0, 1'b1, 32'd3, 32'd0, 1'b0, 7'b0101011, 32'd0};
        tbl[11] = '{1'b0, 1'b0, 32'd3, 32'd0, 1'b0, 7'b0000010, 32'd0};

        for (int i = 0; i < 12; i++) begin
            ld_req  = tbl[i].ld_req;
            st_req  = tbl[i].st_req;
            ld_len  = tbl[i].ld_len;
            st_len  = tbl[i].st_len;
            agu_end = tbl[i].agu_end;
            step();
            check($sformatf("tbl%0d_flags", i), {25'd0, flags}, {25'd0, tbl[i].exp_flags});
            check($sformatf("tbl%0d_len", i), agu_len, tbl[i].exp_len);
        end

        // Load-only access with an 8-cycle run
        do_reset();
        ld_req = 1; ld_len = 32'd8;
        step();
        check("ld_issue_flags", {25'd0, flags}, {25'd0, 7'b1000101});
        check("ld_issue_len", agu_len, 32'd8);
        check("ld_issue_stride", agu_stride, 32'd2);
        check("ld_issue_base", agu_base, 32'h100);
        for (int i = 0; i < 8; i++) step();
        check("ld_run_flags", {25'd0, flags}, {25'd0, 7'b1000001});
        agu_end = 1;
        step();
        check("ld_done_flags", {25'd0, flags}, {25'd0, 7'b1010001});
        agu_end = 0; ld_req = 0;
        step();
        check("ld_idle_flags", {25'd0, flags}, 32'd0);

        // Fairness with both requests held
        do_reset();
        ld_req = 1; st_req = 1; ld_len = 32'd2; st_len = 32'd2; agu_end = 1;
        viol = 0;
        for (int c = 0; c < 200 && got_st.size() < 4; c++) begin
            step();
            if (ld_gnt && st_gnt) viol++;
            if (agu_req) got_st.push_back(st_gnt);
        end
        check("fair_count", got_st.size(), 32'd4);
        for (int i = 0; i < 4 && i < got_st.size(); i++)
            check($sformatf("fair_order%0d", i), {31'd0, got_st[i]}, (i % 2 == 1) ? 32'd1 : 32'd0);
        check("fair_excl", viol, 32'd0);

        // Reset asserted while in RUN
        do_reset();
        st_req = 0; ld_req = 1; ld_len = 32'd8; agu_end = 0;
        step();
        check("rst_issue", {31'd0, agu_req}, 32'd1);
        step();
        step();
        reset = 0;
        #1;
        check("rst_async_flags", {25'd0, flags}, 32'd0);
        check("rst_async_len", agu_len, 32'd0);
        check("rst_async_stride", agu_stride, 32'd0);
        step();
        check("rst_hold_flags", {25'd0, flags}, 32'd0);
        reset = 1;
        step();
        check("rst_regrant", {25'd0, flags}, {25'd0, 7'b1000101});

        // Store request arriving while the load runs
        do_reset();
        ld_req = 1; ld_len = 32'd3;
        step();
        step();
        st_req = 1; st_len = 32'd4;
        step();
        check("late_run", {25'd0, flags}, {25'd0, 7'b1000001});
        agu_end = 1;
        step();
        check("late_done", {25'd0, flags}, {25'd0, 7'b1010001});
        agu_end = 0; ld_req = 0;
        step();
        check("late_idle", {25'd0, flags}, 32'd0);
        step();
        check("late_st_issue", {25'd0, flags}, {25'd0, 7'b0100111});
        check("late_st_base", agu_base, 32'h200);

        // Random traffic against the model
        do_reset();
        m_busy = 0; m_st = 0; m_fin = 0; m_last_st = 1; m_we = 0; m_age = 0;
        m_len = 0; m_stride = 0; m_base = 0;
        for (int c = 0; c < 3000; c++) begin
            ld_req    = ($urandom_range(0, 2) != 0);
            st_req    = ($urandom_range(0, 2) != 0);
            ld_len    = ($urandom_range(0, 3) == 0) ? 32'd0 : W'($urandom_range(1, 20));
            st_len    = ($urandom_range(0, 3) == 0) ? 32'd0 : W'($urandom_range(1, 20));
            ld_stride = $urandom; ld_base = $urandom;
            st_stride = $urandom; st_base = $urandom;
            agu_end   = ($urandom_range(0, 3) == 0);
            @(posedge clock);
            if (!m_busy) begin
                if (ld_req || st_req) begin
                    m_st      = st_req && (!ld_req || !m_last_st);
                    m_last_st = m_st;
                    m_len     = m_st ? st_len : ld_len;
                    m_stride  = m_st ? st_stride : ld_stride;
                    m_base    = m_st ? st_base : ld_base;
                    m_we      = m_st;
                    m_busy    = 1;
                    m_age     = 0;
                    m_fin     = (m_len == 0);
                end
            end else if (m_fin) begin
                m_busy = 0;
            end else begin
                if (m_age >= 1 && agu_end) m_fin = 1;
                m_age++;
            end
            step();
            e_flags = {m_busy && !m_st, m_busy && m_st, m_busy && m_fin && !m_st,
                       m_busy && m_fin && m_st, m_busy && m_age == 0 && m_len != 0, m_we, m_busy};
            check("rnd_flags", {25'd0, flags}, {25'd0, e_flags});
            check("rnd_len", agu_len, m_len);
            check("rnd_stride", agu_stride, m_stride);
            check("rnd_base", agu_base, m_base);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
